// File: rtl/next_clock_enables_if.sv
// Divider reprogramming channel for next_clock_enables: valid/ready update request
// carrying target channel, new divider and start phase.
interface next_clock_enables_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/next_clock_enables.sv
// Clock-enable generator for the Next core: NUM_CH runtime-reprogrammable enables plus
// PLL-lock reset sequencing. Define NEXT_CE_PHASE_EN to let updates set per-channel start phase.
module next_clock_enables #(
  parameter int                      NUM_CH   = 4,
  parameter int                      DIV_W    = 8,
  parameter int                      LOCK_DLY = 16,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd39, 8'd19, 8'd9, 8'd4}
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  next_clock_enables_if.slave  cfg,
  output logic [NUM_CH-1:0]    ce,
  output logic [NUM_CH-1:0]    ce_n,
  output logic                 running,
  output logic                 sync_rst_n
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = $clog2(LOCK_DLY + 1);

  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

  function automatic logic [DIV_W-1:0] half_of(input logic [DIV_W-1:0] d);
    logic [DIV_W:0] s;
    s = {1'b0, d} + {{DIV_W{1'b0}}, 1'b1};
    return s[DIV_W:1];
  endfunction

  state_t           state_q;
  logic [SET_W-1:0] settle_q;
  logic             lk_meta_q, lk_s_q;
  logic             running_q, srst_n_q;
  logic             run_d;

  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] phase_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d, ce_n_q, ce_n_d;

  logic             pend_q, pend_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] pend_phase_q, pend_phase_d;
  logic             ready_q, ready_d;
  logic             ch_ok;

  assign ch_ok = (32'(cfg.cfg_ch) < 32'(NUM_CH));

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  // running in the next cycle: staying in RUN, or finishing the settle count
  assign run_d = lk_s_q && ((state_q == RUN) ||
                 ((state_q == SETTLE) && (settle_q == SET_W'(LOCK_DLY - 1))));

  // Lock sequencer: WAIT_LOCK -> SETTLE (LOCK_DLY cycles) -> RUN, any lock loss returns to WAIT_LOCK
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      settle_q  <= '0;
      running_q <= 1'b0;
      srst_n_q  <= 1'b0;
    end else begin
      running_q <= run_d;
      srst_n_q  <= run_d;
      case (state_q)
        WAIT_LOCK: begin
          settle_q <= '0;
          if (lk_s_q) state_q <= SETTLE;
          else        state_q <= WAIT_LOCK;
        end
        SETTLE: begin
          if (!lk_s_q) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
          end else if (run_d) begin
            state_q  <= RUN;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + {{(SET_W-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          settle_q <= '0;
          if (!lk_s_q) state_q <= WAIT_LOCK;
          else         state_q <= RUN;
        end
        default: begin
          state_q  <= WAIT_LOCK;
          settle_q <= '0;
        end
      endcase
    end
  end

  // Counters, update handshake and next enable values
  always_comb begin
    div_d        = div_q;
    phase_d      = phase_q;
    pend_d       = pend_q;
    pend_ch_d    = pend_ch_q;
    pend_div_d   = pend_div_q;
    pend_phase_d = pend_phase_q;
    ready_d      = ready_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!running_q)
        cnt_d[i] = (phase_q[i] < div_q[i]) ? phase_q[i] : div_q[i];
      else if (cnt_q[i] == div_q[i])
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + {{(DIV_W-1){1'b0}}, 1'b1};
    end
    // A running channel only takes its new divider on its own wrap, so no period is cut short
    if (pend_q && (!running_q || (cnt_q[pend_ch_q] == div_q[pend_ch_q]))) begin
      div_d[pend_ch_q]   = pend_div_q;
      phase_d[pend_ch_q] = pend_phase_q;
      pend_d             = 1'b0;
      ready_d            = 1'b1;
    end else if (cfg.cfg_valid && ready_q && ch_ok) begin
      pend_d     = 1'b1;
      pend_ch_d  = cfg.cfg_ch;
      pend_div_d = cfg.cfg_div;
`ifdef NEXT_CE_PHASE_EN
      pend_phase_d = cfg.cfg_phase;
`else
      pend_phase_d = '0;
`endif
      ready_d    = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      ce_d[i]   = run_d && (cnt_d[i] == '0);
      ce_n_d[i] = run_d && (cnt_d[i] == half_of(div_d[i]));
    end
  end

  // Channel state, pending update and registered enables
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
      ready_q      <= 1'b1;
      ce_q         <= '0;
      ce_n_q       <= '0;
    end else begin
      div_q        <= div_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_ch_q    <= pend_ch_d;
      pend_div_q   <= pend_div_d;
      pend_phase_q <= pend_phase_d;
      ready_q      <= ready_d;
      ce_q         <= ce_d;
      ce_n_q       <= ce_n_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign ce            = ce_q;
  assign ce_n          = ce_n_q;
  assign running       = running_q;
  assign sync_rst_n    = srst_n_q;
endmodule

// File: tb/tb_next_clock_enables.sv
// Self-checking bench for next_clock_enables: lock sequencing, default rates, glitch-free
// reprogramming, lock loss, phase start, div=0 and out-of-range channel handling.
module tb_next_clock_enables;
  localparam int LOCK_DLY = 16;

  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic [3:0] ce, ce_n;
  logic       running, sync_rst_n;
  logic [2:0] ce3, ce_n3;
  logic       running3, sync_rst_n3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];
  int exp2_q[$];

  next_clock_enables_if #(.NUM_CH(4), .DIV_W(8)) cfg_if ();
  next_clock_enables_if #(.NUM_CH(3), .DIV_W(8)) cfg3_if ();

  next_clock_enables #(.NUM_CH(4), .DIV_W(8), .LOCK_DLY(LOCK_DLY),
                       .DIV_INIT({8'd39, 8'd19, 8'd9, 8'd4})) u_dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg(cfg_if),
    .ce(ce), .ce_n(ce_n), .running(running), .sync_rst_n(sync_rst_n));

  next_clock_enables #(.NUM_CH(3), .DIV_W(8), .LOCK_DLY(LOCK_DLY),
                       .DIV_INIT({8'd19, 8'd9, 8'd4})) u_dut3 (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg(cfg3_if),
    .ce(ce3), .ce_n(ce_n3), .running(running3), .sync_rst_n(sync_rst_n3));

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_phase = '0;
    cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_ch = '0; cfg3_if.cfg_div = '0; cfg3_if.cfg_phase = '0;
    repeat (3) tick();
    n_tests++; if (ce !== 4'h0) begin n_fail++; $display("FAIL reset_ce: got %h expected 0", ce); end
    n_tests++; if (ce_n !== 4'h0) begin n_fail++; $display("FAIL reset_ce_n: got %h expected 0", ce_n); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_tests++; if (sync_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sync_rst_n: got %b expected 0", sync_rst_n); end
    n_tests++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready); end
  endtask

  task automatic test_lock_seq();
    int e;
    @(negedge refclk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 9) tick();
    pll_locked = 1'b1;
    exp_q.push_back(10 + 2 + LOCK_DLY);
    for (int k = 0; k < 100 && running !== 1'b1; k++) tick();
    e = exp_q.pop_front();
    n_tests++;
    if (running !== 1'b1 || cyc != e) begin
      n_fail++; $display("FAIL lock_seq_cycle: running=%b at cycle %0d expected rise at %0d", running, cyc, e);
    end
    n_tests++; if (sync_rst_n !== 1'b1) begin n_fail++; $display("FAIL lock_seq_sync_rst_n: got %b expected 1", sync_rst_n); end
    n_tests++; if (ce !== 4'hF) begin n_fail++; $display("FAIL lock_seq_ce: got %h expected f", ce); end
    n_tests++; if (ce_n !== 4'h0) begin n_fail++; $display("FAIL lock_seq_ce_n: got %h expected 0", ce_n); end
  endtask

  task automatic test_defaults();
    int pulses[4];
    int divs[4];
    int e;
    divs = '{4, 9, 19, 39};
    for (int c = 0; c < 4; c++) pulses[c] = 0;
    for (int i = 0; i < 280; i++) begin
      for (int c = 0; c < 4; c++) if (ce[c] === 1'b1) pulses[c]++;
      if (ce_n[0] === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL defaults_ce_n0: unexpected pulse at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e) begin n_fail++; $display("FAIL defaults_ce_n0: pulse at %0d expected %0d", cyc, e); end
        end
      end
      if (ce[0] === 1'b1) exp_q.push_back(cyc + 2);
      tick();
    end
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (pulses[c] != 280 / (divs[c] + 1)) begin
        n_fail++; $display("FAIL defaults_count ch%0d: got %0d expected %0d", c, pulses[c], 280 / (divs[c] + 1));
      end
    end
  endtask

  task automatic test_reprogram();
    int t, e;
    for (int k = 0; k < 40 && ce[1] !== 1'b1; k++) tick();
    t = cyc;
    n_tests++; if (ce[1] !== 1'b1) begin n_fail++; $display("FAIL reprog_wait: ce[1]=%b expected 1", ce[1]); end
    repeat (4) tick();
    n_tests++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reprog_ready_pre: got %b expected 1", cfg_if.cfg_ready); end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd3; cfg_if.cfg_phase = 8'd0;
    exp_q.push_back(t + 10); exp_q.push_back(t + 14); exp_q.push_back(t + 18); exp_q.push_back(t + 22);
    tick();
    cfg_if.cfg_valid = 1'b0;
    while (cyc <= t + 22) begin
      if (cyc == t + 5 || cyc == t + 9) begin
        n_tests++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reprog_ready_busy: got %b expected 0 at cycle %0d", cfg_if.cfg_ready, cyc); end
      end
      if (cyc == t + 10) begin
        n_tests++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reprog_ready_back: got %b expected 1", cfg_if.cfg_ready); end
      end
      if (ce[1] === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL reprog_ce1: unexpected pulse at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e) begin n_fail++; $display("FAIL reprog_ce1: pulse at %0d expected %0d", cyc, e); end
        end
      end
      tick();
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reprog_missing: %0d pulses missing expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_phase_cfg();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd4; cfg_if.cfg_phase = 8'd2;
    tick();
    cfg_if.cfg_valid = 1'b0;
    for (int k = 0; k < 60 && cfg_if.cfg_ready !== 1'b1; k++) tick();
    n_tests++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL phase_cfg_ready: got %b expected 1", cfg_if.cfg_ready); end
  endtask

  task automatic test_lock_loss();
    int c, r, e;
    c = cyc;
    pll_locked = 1'b0;
    exp_q.push_back(c + 3);
    for (int k = 0; k < 10 && running === 1'b1; k++) tick();
    e = exp_q.pop_front();
    n_tests++; if (running !== 1'b0 || cyc != e) begin n_fail++; $display("FAIL lockloss_drop: running=%b at %0d expected 0 at %0d", running, cyc, e); end
    n_tests++; if (sync_rst_n !== 1'b0) begin n_fail++; $display("FAIL lockloss_sync_rst_n: got %b expected 0", sync_rst_n); end
    while (cyc < c + 5) tick();
    pll_locked = 1'b1;
    exp_q.push_back(c + 24);
    for (int k = 0; k < 60 && running !== 1'b1; k++) begin
      n_tests++; if (ce !== 4'h0) begin n_fail++; $display("FAIL lockloss_ce_idle: got %h expected 0 at %0d", ce, cyc); end
      tick();
    end
    e = exp_q.pop_front();
    n_tests++; if (running !== 1'b1 || cyc != e) begin n_fail++; $display("FAIL lockloss_rerun: running=%b at %0d expected rise at %0d", running, cyc, e); end
    r = cyc;
`ifdef NEXT_CE_PHASE_EN
    exp_q.push_back(r + 3); exp_q.push_back(r + 8); exp_q.push_back(r + 13); exp_q.push_back(r + 18);
`else
    exp_q.push_back(r); exp_q.push_back(r + 5); exp_q.push_back(r + 10); exp_q.push_back(r + 15); exp_q.push_back(r + 20);
`endif
    exp2_q.push_back(r); exp2_q.push_back(r + 20);
    while (cyc <= r + 20) begin
      if (ce[0] === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL phase_ce0: unexpected pulse at %0d", cyc); end
        else begin e = exp_q.pop_front(); if (cyc != e) begin n_fail++; $display("FAIL phase_ce0: pulse at %0d expected %0d", cyc, e); end end
      end
      if (ce[2] === 1'b1) begin
        n_tests++;
        if (exp2_q.size() == 0) begin n_fail++; $display("FAIL phase_ce2: unexpected pulse at %0d", cyc); end
        else begin e = exp2_q.pop_front(); if (cyc != e) begin n_fail++; $display("FAIL phase_ce2: pulse at %0d expected %0d", cyc, e); end end
      end
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_fail++; $display("FAIL phase_missing: %0d/%0d pulses missing expected 0/0", exp_q.size(), exp2_q.size());
    end
    exp_q.delete(); exp2_q.delete();
  endtask

  task automatic test_div_zero();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 8'd0; cfg_if.cfg_phase = 8'd0;
    tick();
    cfg_if.cfg_valid = 1'b0;
    for (int k = 0; k < 60 && cfg_if.cfg_ready !== 1'b1; k++) tick();
    n_tests++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL div0_ready: got %b expected 1", cfg_if.cfg_ready); end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (ce[3] !== 1'b1 || ce_n[3] !== 1'b1) begin
        n_fail++; $display("FAIL div0_every_cycle: ce=%b ce_n=%b expected 1/1 at %0d", ce[3], ce_n[3], cyc);
      end
      tick();
    end
  endtask

  task automatic test_bad_channel();
    cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_ch = 2'd3; cfg3_if.cfg_div = 8'd0; cfg3_if.cfg_phase = 8'd0;
    tick();
    n_tests++; if (cfg3_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL badch_ready1: got %b expected 1", cfg3_if.cfg_ready); end
    tick();
    cfg3_if.cfg_valid = 1'b0;
    n_tests++; if (cfg3_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL badch_ready2: got %b expected 1", cfg3_if.cfg_ready); end
  endtask

  task automatic test_reset_mid();
    int r, e;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd5; cfg_if.cfg_phase = 8'd0;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_tests++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: got %b expected 0", cfg_if.cfg_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", cfg_if.cfg_ready); end
    n_tests++; if (running !== 1'b0 || sync_rst_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_run: running=%b sync_rst_n=%b expected 0/0", running, sync_rst_n); end
    n_tests++; if (ce !== 4'h0 || ce_n !== 4'h0) begin n_fail++; $display("FAIL rstmid_ce: ce=%h ce_n=%h expected 0/0", ce, ce_n); end
    tick(); tick();
    @(negedge refclk);
    rst_n = 1'b1;
    for (int k = 0; k < 60 && running !== 1'b1; k++) tick();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL rstmid_relock: running=%b expected 1", running); end
    r = cyc;
    exp_q.push_back(r); exp_q.push_back(r + 40);
    exp2_q.push_back(r); exp2_q.push_back(r + 20); exp2_q.push_back(r + 40);
    while (cyc <= r + 40) begin
      if (ce[3] === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_ce3: unexpected pulse at %0d", cyc); end
        else begin e = exp_q.pop_front(); if (cyc != e) begin n_fail++; $display("FAIL rstmid_ce3: pulse at %0d expected %0d", cyc, e); end end
      end
      if (ce[2] === 1'b1) begin
        n_tests++;
        if (exp2_q.size() == 0) begin n_fail++; $display("FAIL rstmid_ce2: unexpected pulse at %0d", cyc); end
        else begin e = exp2_q.pop_front(); if (cyc != e) begin n_fail++; $display("FAIL rstmid_ce2: pulse at %0d expected %0d", cyc, e); end end
      end
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_missing: %0d/%0d pulses missing expected 0/0", exp_q.size(), exp2_q.size());
    end
    exp_q.delete(); exp2_q.delete();
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_defaults();
    test_reprogram();
    test_phase_cfg();
    test_lock_loss();
    test_div_zero();
    test_bad_channel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
